bnn_param_loader: RTL and testbench



---
 rtl/bnn_param_loader.sv | 90 +++++++++
 tb/tb_bnn_param_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bnn_param_loader.sv
// rtl/bnn_param_loader.sv - serial weight/threshold loader with atomic commit to the active BNN bank
module bnn_param_loader #(
  parameter  int N_IN       = 8,
  parameter  int N_NEURON   = 4,
  parameter  int TH_W       = 4,
  localparam int PARAM_BITS = N_NEURON * (N_IN + TH_W),
  localparam int CNT_W      = $clog2(PARAM_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  setup,
  input  logic                  param_in,
  output logic [PARAM_BITS-1:0] param_bits,
  output logic                  params_valid,
  output logic                  busy,
  output logic                  load_err,
  output logic [CNT_W-1:0]      bit_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(PARAM_BITS);

  state_t                  state, state_n;
  logic [PARAM_BITS-1:0]   shadow, shadow_n, bank_n;
  logic [CNT_W-1:0]        cnt_n;
  logic                    valid_n, err_n, setup_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow       <= '0;
      param_bits   <= '0;
      bit_count    <= '0;
      params_valid <= 1'b0;
      busy         <= 1'b0;
      load_err     <= 1'b0;
      setup_q      <= 1'b0;
    end else begin
      state        <= state_n;
      shadow       <= shadow_n;
      param_bits   <= bank_n;
      bit_count    <= cnt_n;
      params_valid <= valid_n;
      busy         <= (state_n == LOAD);
      load_err     <= err_n;
      setup_q      <= setup;
    end
  end

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    bank_n   = param_bits;
    cnt_n    = bit_count;
    valid_n  = params_valid;
    err_n    = load_err;
    case (state)
      LOAD: begin
        if (setup) begin
          if (bit_count == FULL) begin
            state_n = ERR;
            err_n   = 1'b1;
          end else begin
            shadow_n = {shadow[PARAM_BITS-2:0], param_in};
            cnt_n    = bit_count + 1'b1;
          end
        end else if (bit_count == FULL) begin
          state_n = DONE;
          bank_n  = shadow;
          valid_n = 1'b1;
        end else begin
          state_n = ERR;
          err_n   = 1'b1;
        end
      end
      // An overflowed frame keeps setup high; wait for a low cycle before re-arming.
      IDLE, DONE, ERR: begin
        if (setup && (state != ERR || !setup_q)) begin
          state_n  = LOAD;
          shadow_n = {shadow[PARAM_BITS-2:0], param_in};
          cnt_n    = CNT_W'(1);
          err_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bnn_param_loader.sv
// tb/tb_bnn_param_loader.sv - directed self-checking bench for bnn_param_loader
module tb_bnn_param_loader;

  logic        clk = 1'b0;
  logic        rst, setup, param_in;
  logic [47:0] param_bits;
  logic        params_valid, busy, load_err;
  logic [5:0]  bit_count;

  int n_vec = 0;
  int n_err = 0;

  bnn_param_loader dut (
    .clk(clk), .rst(rst), .setup(setup), .param_in(param_in),
    .param_bits(param_bits), .params_valid(params_valid), .busy(busy),
    .load_err(load_err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic b);
    setup    = s;
    param_in = b;
    @(posedge clk);
    #1;
  endtask

  // Bits past 48 are sent as ones; checks busy right after the first bit.
  task automatic stream(input logic [47:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, (i < 48) ? v[47-i] : 1'b1);
      if (i == 0) begin
        chk("busy_first_bit", busy, 1);
        chk("err_clear_first_bit", load_err, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; setup = 1'b0; param_in = 1'b0;
    step(0, 0);
    step(0, 0);
    chk("rst_bank", param_bits, 0);
    chk("rst_valid", params_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", load_err, 0);
    chk("rst_cnt", bit_count, 0);
    rst = 1'b0;
    step(0, 0);

    // Good load
    stream(48'hA5A5_F00F_C33C, 48);
    chk("good_cnt_48", bit_count, 48);
    chk("good_bank_unchanged_mid", param_bits, 0);
    step(0, 0);
    chk("good_bank", param_bits, 48'hA5A5F00FC33C);
    chk("good_valid", params_valid, 1);
    chk("good_err", load_err, 0);
    chk("good_busy_drop", busy, 0);
    chk("good_cnt", bit_count, 48);
    chk("n3_threshold", param_bits[47:44], 4'hA);
    chk("n0_weights", param_bits[7:0], 8'h3C);

    // Underflow
    stream(48'hFFFF_FFFF_FFFF, 47);
    step(0, 0);
    chk("under_err", load_err, 1);
    chk("under_cnt", bit_count, 47);
    chk("under_bank", param_bits, 48'hA5A5F00FC33C);
    chk("under_valid", params_valid, 1);

    // Overflow
    stream(48'hFFFF_FFFF_FFFF, 48);
    chk("over_pre_err", load_err, 0);
    step(1, 1);
    chk("over_err", load_err, 1);
    chk("over_cnt", bit_count, 48);
    chk("over_busy", busy, 0);
    step(1, 0);
    step(1, 1);
    chk("over_ignored_cnt", bit_count, 48);
    chk("over_ignored_busy", busy, 0);
    step(0, 0);
    chk("over_bank", param_bits, 48'hA5A5F00FC33C);
    chk("over_err_sticky", load_err, 1);

    // Back-to-back
    stream(48'hDEAD_BEEF_CAFE, 48);
    step(0, 0);
    chk("b2b_A_bank", param_bits, 48'hDEADBEEFCAFE);
    chk("b2b_A_err", load_err, 0);
    stream(48'h1234_5678_9ABC, 48);
    chk("b2b_B_midbank", param_bits, 48'hDEADBEEFCAFE);
    chk("b2b_B_miderr", load_err, 0);
    step(0, 0);
    chk("b2b_B_bank", param_bits, 48'h123456789ABC);
    chk("b2b_B_err", load_err, 0);
    chk("b2b_B_valid", params_valid, 1);

    // Reset mid-load
    stream(48'h5555_AAAA_0F0F, 20);
    chk("mid_cnt_20", bit_count, 20);
    rst = 1'b1;
    step(1, 1);
    chk("midrst_bank", param_bits, 0);
    chk("midrst_valid", params_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", load_err, 0);
    chk("midrst_cnt", bit_count, 0);
    rst = 1'b0;
    step(0, 0);
    stream(48'h0F1E_2D3C_4B5A, 48);
    step(0, 0);
    chk("post_rst_bank", param_bits, 48'h0F1E2D3C4B5A);
    chk("post_rst_valid", params_valid, 1);
    chk("post_rst_err", load_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
